// File: rtl/wbuart_pkg.sv
// Register map, field positions and FSM states shared by the UART TX scheduler.
// PKT_LOCK build option: WBUART_TX_SCHEDULER_PKT_LOCK_EN.
package wbuart_pkg;

  localparam int UART_SR   = 0;
  localparam int UART_CR   = 1;
  localparam int UART_RXDR = 2;
  localparam int UART_TXDR = 3;

  localparam int SR_TXE         = 1;
  localparam int CR_CLK_DIV_MSB = 31;
  localparam int CR_CLK_DIV_LSB = 16;
  localparam int CR_S           = 4;
  localparam int CR_P_MSB       = 3;
  localparam int CR_P_LSB       = 2;
  localparam int CR_DS          = 1;
  localparam int CR_EN          = 0;

  typedef enum logic [1:0] {
    INIT_CR,
    IDLE,
    POLL,
    WRITE
  } state_e;

  function automatic logic [31:0] reg_adr(
    input logic [31:0] base,
    input int          idx
  );
    return base + (32'(idx) << 2);
  endfunction

  function automatic logic [31:0] cr_word(
    input logic [15:0] div,
    input logic        s,
    input logic [1:0]  p,
    input logic        ds
  );
    logic [31:0] w;
    w = '0;
    w[CR_CLK_DIV_MSB:CR_CLK_DIV_LSB] = div;
    w[CR_S] = s;
    w[CR_P_MSB:CR_P_LSB] = p;
    w[CR_DS] = ds;
    w[CR_EN] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/wbuart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the
// pointer, wrapping; the pointer register lives in the parent.
module rr_arbiter #(
  parameter int NB_REQ = 4,
  parameter int IW     = $clog2(NB_REQ)
) (
  input  logic [NB_REQ-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [NB_REQ-1:0] gnt_o,
  output logic [IW-1:0]     idx_o,
  output logic              any_o
);

  logic [IW-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      j = IW'((int'(ptr_i) + i) % NB_REQ);
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/wbuart_tx_scheduler.sv
// Wishbone master that configures a wbuart and multiplexes NB_REQ byte
// streams onto its transmitter. Option: WBUART_TX_SCHEDULER_PKT_LOCK_EN.
module wbuart_tx_scheduler
  import wbuart_pkg::*;
#(
  parameter int          NB_REQ      = 4,
  parameter logic [31:0] UART_BASE   = 32'h0000_0000,
  parameter logic [15:0] CFG_CLK_DIV = 16'd868,
  parameter logic        CFG_DS      = 1'b0,
  parameter logic [1:0]  CFG_P       = 2'b00,
  parameter logic        CFG_S       = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NB_REQ-1:0]     req_valid_i,
  input  logic [8*NB_REQ-1:0]   req_data_i,
`ifdef WBUART_TX_SCHEDULER_PKT_LOCK_EN
  input  logic [NB_REQ-1:0]     req_last_i,
`endif
  output logic [NB_REQ-1:0]     req_ready_o,
  output logic                  busy_o,
  output logic [31:0]           wb_adr_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  output logic                  wb_we_o,
  output logic [3:0]            wb_sel_o,
  output logic                  wb_stb_o,
  input  logic                  wb_ack_i,
  output logic                  wb_cyc_o,
  input  logic                  wb_stall_i
);

  localparam int IW = $clog2(NB_REQ);

  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [7:0] data_q, data_d;
  logic cyc_q, cyc_d, stb_q, stb_d;
  logic we_q, we_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;

  logic [NB_REQ-1:0] arb_req, gnt;
  logic [IW-1:0] gnt_idx, nxt_ptr;
  logic any_gnt;

`ifdef WBUART_TX_SCHEDULER_PKT_LOCK_EN
  logic lock_q, lock_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;

  // While locked only the owning requester is visible to the arbiter.
  assign arb_req = lock_q ? (req_valid_i & (NB_REQ'(1) << lock_idx_q))
                          : req_valid_i;
`else
  assign arb_req = req_valid_i;
`endif

  rr_arbiter #(
    .NB_REQ(NB_REQ),
    .IW    (IW)
  ) u_arb (
    .req_i(arb_req),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(gnt_idx),
    .any_o(any_gnt)
  );

  assign nxt_ptr = (gnt_idx == IW'(NB_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    data_d      = data_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    req_ready_o = '0;
`ifdef WBUART_TX_SCHEDULER_PKT_LOCK_EN
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
`endif
    if (stb_q && !wb_stall_i) stb_d = 1'b0;
    if (cyc_q && wb_ack_i) begin
      cyc_d = 1'b0;
      stb_d = 1'b0;
    end
    unique case (state_q)
      INIT_CR: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
          we_d  = 1'b1;
          adr_d = reg_adr(UART_BASE, UART_CR);
          dat_d = cr_word(CFG_CLK_DIV, CFG_S, CFG_P, CFG_DS);
        end else if (wb_ack_i) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (any_gnt) begin
          req_ready_o = gnt;
          data_d  = req_data_i[{gnt_idx, 3'b000} +: 8];
          state_d = POLL;
          // Grant cycle also launches the first status read.
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          adr_d   = reg_adr(UART_BASE, UART_SR);
          dat_d   = '0;
`ifdef WBUART_TX_SCHEDULER_PKT_LOCK_EN
          if (req_last_i[gnt_idx]) begin
            lock_d = 1'b0;
            ptr_d  = nxt_ptr;
          end else begin
            lock_d     = 1'b1;
            lock_idx_d = gnt_idx;
          end
`else
          ptr_d   = nxt_ptr;
`endif
        end
      end
      POLL: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
          we_d  = 1'b0;
          adr_d = reg_adr(UART_BASE, UART_SR);
          dat_d = '0;
        end else if (wb_ack_i) begin
          state_d = wb_dat_i[SR_TXE] ? WRITE : POLL;
        end
      end
      WRITE: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
          we_d  = 1'b1;
          adr_d = reg_adr(UART_BASE, UART_TXDR);
          dat_d = {24'b0, data_q};
        end else if (wb_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = INIT_CR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= INIT_CR;
      ptr_q      <= '0;
      data_q     <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
`ifdef WBUART_TX_SCHEDULER_PKT_LOCK_EN
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      data_q     <= data_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
`ifdef WBUART_TX_SCHEDULER_PKT_LOCK_EN
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
`endif
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = 4'hF;

  logic unused_dat;
  assign unused_dat = ^{wb_dat_i[31:SR_TXE+1], wb_dat_i[SR_TXE-1:0]};

endmodule
